eigen_serializer: RTL and testbench
===================================

# eigen_serializer

Output stage directly downstream of the eigen block. It captures one packed result vector of `NUM_BYTES` bytes on a single-cycle valid and streams it out one byte per handshake to the Ethernet/UART transmit path. A ready/valid interface applies downstream backpressure. Upstream is stalled by deasserting `axiir` while a frame is in flight.

## Interface
Parameters:
- `NUM_BYTES`, 13, number of bytes in one result vector (4*3+1, matching the eigen output width); must be ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion takes effect immediately; release is synchronised to `clk`.
- `axiid`  in  `[NUM_BYTES-1:0][7:0]`  packed result vector from the eigen block; byte 0 is transmitted first.
- `axiiv`  in  1  input valid; the vector is captured when `axiiv && axiir`.
- `axiir`  out  1  input ready; high only in IDLE.
- `axiod`  out  8  output byte.
- `axiov`  out  1  output valid.
- `axior`  in  1  downstream ready; a byte transfers when `axiov && axior`.
- `axiol`  out  1  last-byte flag; high with the final byte of the frame.

## Operation
- States: IDLE, SEND, and CSUM (CSUM exists only with checksum enabled).
- IDLE:
  - `axiir`=1, `axiov`=0.
  - On `axiiv`=1, copy `axiid` into the internal frame register, clear the byte index to 0, and go to SEND.
- SEND:
  - `axiod` = frame byte[index], `axiov`=1.
  - On each handshake, increment the index.
  - On the handshake of byte `NUM_BYTES-1`, go to IDLE, or to CSUM when checksum is enabled.
- CSUM:
  - `axiod` = running XOR of all payload bytes, `axiov`=1.
  - On handshake, go to IDLE.
- `axiol`=1 only while the frame's final byte is presented: payload byte `NUM_BYTES-1`, or the checksum byte when enabled.
- While `axiov`=1 and `axior`=0, `axiod`, `axiol` and `axiov` hold stable. No byte is dropped or duplicated.
- `axiiv` while busy is ignored. The frame register is not modified.
- The index counter is `$clog2(NUM_BYTES)` bits wide and never exceeds `NUM_BYTES-1`; there is no wrap within a frame.
- The checksum accumulator is 8 bits.
  - It clears on capture.
  - It XORs in each byte at its handshake.
- Reset mid-frame aborts the frame. After release the block is in IDLE; there is no partial resume.

## Timing
- Reset values:
  - `axiov`=0, `axiod`=8'h00, `axiol`=0.
  - `axiir`=1 (decoded from state == IDLE).
  - Index and checksum = 0.
- Latency: capture at edge N; byte 0 is valid in the cycle after edge N.
- With `axior` held high: one byte per cycle, so `axiov` is high for `NUM_BYTES` consecutive cycles, plus 1 with checksum.
- `axiir` is low from the cycle after capture until the cycle after the final handshake.
- There is no same-cycle re-capture. Back-to-back frames have exactly one idle cycle (`axiov`=0) between `axiol` and the next byte 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `axior` or `axiiv` to any output.

## Configuration
- `SERIALIZER_CHECKSUM_EN` defined:
  - The CSUM state is present.
  - Frame length is `NUM_BYTES+1`.
  - The last byte is the XOR of all payload bytes, and `axiol` moves to it.
- Not defined:
  - No checksum logic; CSUM and the accumulator are compiled out.
  - Frame length is `NUM_BYTES`.

## Test plan
- Basic frame:
  - Stimulus: `axiid` bytes 0..12 = 8'h01..8'h0D, single-cycle `axiiv`, `axior`=1.
  - Required: bytes 01..0D on 13 consecutive cycles starting the cycle after capture; `axiol` on 0D.
  - With the macro: a 14th byte 8'h01 carrying `axiol`.
- Backpressure:
  - Stimulus: same frame, `axior` alternating 1,0 each cycle.
  - Required: each byte held through its low cycles; sequence exactly 01..0D with no duplicates or drops; completes in 26 cycles (28 with checksum).
- Busy input:
  - Stimulus: assert `axiiv` with all 8'hAA while byte 3 is in flight.
  - Required: `axiir`=0, frame unchanged (01..0D), and no second frame follows.
- Reset mid-frame:
  - Stimulus: drive `rst`=0 after byte 5 is accepted.
  - Required: `axiov`, `axiol` and `axiod` go to 0 immediately. After release, a new capture starts at byte 0.
- Back-to-back:
  - Stimulus: hold `axiiv`=1 with a constant vector.
  - Required: frames repeat with exactly one `axiov`=0 cycle between `axiol` and the next byte 0; `axiir` pulses for that single cycle.
- Checksum (macro on):
  - Stimulus: all 13 bytes = 8'hFF.
  - Required: checksum byte 8'hFF.
  - Stimulus: bytes alternating 8'h5A and 8'hA5, starting 8'h5A.
  - Required: checksum 8'h5A.

Source files
------------

// File: rtl/eigen_serializer.sv
// eigen_serializer: captures a NUM_BYTES result vector and streams it out byte-wise over ready/valid.
// Optional trailing XOR checksum byte when SERIALIZER_CHECKSUM_EN is defined.
module eigen_serializer #(
  parameter int NUM_BYTES = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_BYTES-1:0][7:0] axiid,
  input  logic                      axiiv,
  output logic                      axiir,
  output logic [7:0]                axiod,
  output logic                      axiov,
  input  logic                      axior,
  output logic                      axiol
);
  localparam int IW = $clog2(NUM_BYTES);
  localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);
`ifdef SERIALIZER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif
  state_t state, state_n;
  logic [1:0] rst_q;
  logic rst_s_n;
  logic [NUM_BYTES-1:0][7:0] frame;
  logic [IW-1:0] idx;
  logic take;
  // asynchronous assertion, release synchronised to clk
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_q <= 2'b00;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_s_n = rst_q[1];
  assign take = axiov && axior;
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && axiiv) state_n = SEND;
`ifdef SERIALIZER_CHECKSUM_EN
    else if (state == SEND && take && idx == LAST) state_n = CSUM;
    else if (state == CSUM && take) state_n = IDLE;
`else
    else if (state == SEND && take && idx == LAST) state_n = IDLE;
`endif
  end
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) begin
      frame <= '0;
      idx   <= '0;
    end else if (state == IDLE) begin
      if (axiiv) begin
        frame <= axiid;
        idx   <= '0;
      end
    end else if (state == SEND && take) begin
      idx <= (idx == LAST) ? '0 : idx + 1'b1;
    end
  assign axiir = (state == IDLE);
  assign axiov = (state != IDLE);
`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk or negedge rst_s_n)
    if (!rst_s_n) csum <= 8'h00;
    else if (state == IDLE && axiiv) csum <= 8'h00;
    else if (state == SEND && take) csum <= csum ^ frame[idx];
  assign axiod = (state == SEND) ? frame[idx] : (state == CSUM) ? csum : 8'h00;
  assign axiol = (state == CSUM);
`else
  assign axiod = (state == SEND) ? frame[idx] : 8'h00;
  assign axiol = (state == SEND) && (idx == LAST);
`endif
endmodule

// File: tb/tb_eigen_serializer.sv
// tb_eigen_serializer: directed self-checking bench for eigen_serializer.
module tb_eigen_serializer;
  localparam int N = 13;
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int TL = N + 1;
`else
  localparam int TL = N;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0][7:0] axiid = '0;
  logic axiiv = 1'b0;
  logic axior = 1'b0;
  logic axiir, axiov, axiol;
  logic [7:0] axiod;
  int n_chk = 0;
  int n_fail = 0;
  logic [N-1:0][7:0] base, v2, vff, v5a;
  logic [7:0] lastb;
  int k, c;

  always #5 clk = ~clk;

  eigen_serializer #(.NUM_BYTES(N)) dut (
    .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv), .axiir(axiir),
    .axiod(axiod), .axiov(axiov), .axior(axior), .axiol(axiol)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input logic [N-1:0][7:0] f, input int i);
    logic [7:0] x;
    x = 8'h00;
    if (i < N) return f[i];
    for (int j = 0; j < N; j++) x ^= f[j];
    return x;
  endfunction

  task automatic run(input string tag, input logic [N-1:0][7:0] f, output logic [7:0] lb);
    lb = 8'h00;
    axiid = f;
    axiiv = 1'b1;
    axior = 1'b1;
    tick;
    axiiv = 1'b0;
    for (int i = 0; i < TL; i++) begin
      chk({tag, "_v"}, 8'(axiov), 8'd1);
      chk({tag, "_d"}, axiod, exp_byte(f, i));
      chk({tag, "_l"}, 8'(axiol), 8'(i == TL - 1));
      chk({tag, "_r"}, 8'(axiir), 8'd0);
      lb = axiod;
      tick;
    end
    chk({tag, "_end_v"}, 8'(axiov), 8'd0);
    chk({tag, "_end_r"}, 8'(axiir), 8'd1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      base[i] = 8'(i + 1);
      v2[i]   = 8'(8'h10 + i);
      vff[i]  = 8'hFF;
      v5a[i]  = (i % 2 == 0) ? 8'h5A : 8'hA5;
    end
    #2 rst = 1'b0;
    tick;
    tick;
    chk("rst_v", 8'(axiov), 8'd0);
    chk("rst_d", axiod, 8'h00);
    chk("rst_l", 8'(axiol), 8'd0);
    chk("rst_r", 8'(axiir), 8'd1);
    rst = 1'b1;
    tick; tick; tick;

    run("basic", base, lastb);
`ifdef SERIALIZER_CHECKSUM_EN
    chk("basic_csum", lastb, 8'h01);
`else
    chk("basic_last", lastb, 8'h0D);
`endif

    // backpressure: ready high on odd cycles only
    axiid = base;
    axiiv = 1'b1;
    axior = 1'b0;
    tick;
    axiiv = 1'b0;
    k = 0;
    c = 0;
    while (k < TL && c < 4 * TL) begin
      axior = (c % 2 == 1);
      chk("bp_v", 8'(axiov), 8'd1);
      chk("bp_d", axiod, exp_byte(base, k));
      chk("bp_l", 8'(axiol), 8'(k == TL - 1));
      tick;
      if (axior) k++;
      c++;
    end
    chk("bp_cycles", 8'(c), 8'(2 * TL));
    chk("bp_end_v", 8'(axiov), 8'd0);

    // busy input: AA vector offered while byte 3 is presented
    axiid = base;
    axiiv = 1'b1;
    axior = 1'b1;
    tick;
    for (int i = 0; i < TL; i++) begin
      if (i == 3) begin
        axiid = {N{8'hAA}};
        axiiv = 1'b1;
        chk("busy_r", 8'(axiir), 8'd0);
      end else axiiv = 1'b0;
      chk("busy_d", axiod, exp_byte(base, i));
      tick;
    end
    axiiv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("busy_nofollow", 8'(axiov), 8'd0);
      tick;
    end

    // reset after byte 5 is accepted
    axiid = base;
    axiiv = 1'b1;
    axior = 1'b1;
    tick;
    axiiv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("mid_d", axiod, base[i]);
      tick;
    end
    chk("mid_pre_d", axiod, base[6]);
    rst = 1'b0;
    #1;
    chk("mid_rst_v", 8'(axiov), 8'd0);
    chk("mid_rst_l", 8'(axiol), 8'd0);
    chk("mid_rst_d", axiod, 8'h00);
    chk("mid_rst_r", 8'(axiir), 8'd1);
    tick;
    tick;
    rst = 1'b1;
    tick; tick; tick;
    chk("post_rst_idle", 8'(axiov), 8'd0);
    run("post_rst", v2, lastb);

    // back-to-back with axiiv held high
    axiid = v2;
    axiiv = 1'b1;
    axior = 1'b1;
    tick;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < TL; i++) begin
        chk("b2b_v", 8'(axiov), 8'd1);
        chk("b2b_d", axiod, exp_byte(v2, i));
        chk("b2b_l", 8'(axiol), 8'(i == TL - 1));
        tick;
      end
      chk("b2b_gap_v", 8'(axiov), 8'd0);
      chk("b2b_gap_r", 8'(axiir), 8'd1);
      if (f == 1) axiiv = 1'b0;
      tick;
      if (f == 0) chk("b2b_next_r", 8'(axiir), 8'd0);
    end
    chk("b2b_stop", 8'(axiov), 8'd0);

    run("ff", vff, lastb);
    run("alt", v5a, lastb);
`ifdef SERIALIZER_CHECKSUM_EN
    chk("alt_csum", lastb, 8'h5A);
    run("ff2", vff, lastb);
    chk("ff_csum", lastb, 8'hFF);
`else
    chk("alt_last", lastb, 8'h5A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
